// File: rtl/fsm_run_monitor_if.sv
// Event record channel of the run monitor: single-entry valid/ready
// record carrying the run type and its length in cycles.
interface fsm_run_monitor_if #(
  parameter int LEN_W = 8
) ();
  logic             ev_valid;
  logic             ev_ready;
  logic             ev_type;
  logic [LEN_W-1:0] ev_len;

  // Producer side (the monitor)
  modport master (
    output ev_valid,
    output ev_type,
    output ev_len,
    input  ev_ready
  );

  // Consumer side
  modport slave (
    input  ev_valid,
    input  ev_type,
    input  ev_len,
    output ev_ready
  );
endinterface

// File: rtl/fsm_run_monitor.sv
// fsm_run_monitor: watches the one-hot run detector (state vector y, flag z),
// measures each zero-run (state E) and one-run (state I), emits one record
// per completed run through a single-entry event register and keeps
// saturating per-type counters, a drop counter and sticky error flags.
// Optional feature: define MON_MAXLEN_EN to track the longest completed run
// on max_len; without it max_len is tied to 0.
module fsm_run_monitor #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z,
  input  logic [8:0]       y,
  input  logic             clr,
  fsm_run_monitor_if.master ev,
  output logic [CNT_W-1:0] zero_cnt,
  output logic [CNT_W-1:0] one_cnt,
  output logic [7:0]       drop_cnt,
  output logic             ovf,
  output logic             err,
  output logic [LEN_W-1:0] max_len
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZRUN = 2'd1,
    ORUN = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] len_inc;

  logic             in_e, in_i, err_now;
  logic             close_now, close_type;
  logic [LEN_W-1:0] close_len;
  logic             ev_load, ev_drop;

  logic             ev_valid_reg, ev_type_reg;
  logic [LEN_W-1:0] ev_len_reg;
  logic [CNT_W-1:0] zero_cnt_reg, one_cnt_reg;
  logic [7:0]       drop_cnt_reg;
  logic             ovf_reg, err_reg;

  // Classification looks at y alone; an illegal y matches neither E nor I.
  assign in_e    = (y == 9'h010);
  assign in_i    = (y == 9'h100);
  assign err_now = !$onehot(y) || (z != (in_e | in_i));
  assign len_inc = (&len_reg) ? len_reg : (len_reg + LEN_ONE);

  // Monitor state register and current run length
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
    end
  end

  // Next state, run length and run-close detection
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    close_now  = 1'b0;
    close_type = 1'b0;
    close_len  = len_reg;
    case (state_reg)
      IDLE: begin
        if (in_e) begin
          state_next = ZRUN;
          len_next   = LEN_ONE;
        end else if (in_i) begin
          state_next = ORUN;
          len_next   = LEN_ONE;
        end
      end
      ZRUN: begin
        if (in_e) begin
          len_next = len_inc;
        end else begin
          close_now  = 1'b1;
          close_type = 1'b0;
          if (in_i) begin
            state_next = ORUN;
            len_next   = LEN_ONE;
          end else begin
            state_next = IDLE;
            len_next   = '0;
          end
        end
      end
      ORUN: begin
        if (in_i) begin
          len_next = len_inc;
        end else begin
          close_now  = 1'b1;
          close_type = 1'b1;
          if (in_e) begin
            state_next = ZRUN;
            len_next   = LEN_ONE;
          end else begin
            state_next = IDLE;
            len_next   = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        len_next   = '0;
      end
    endcase
  end

  // A closing run lands in the register if it is free or being drained now.
  assign ev_load = close_now && (!ev_valid_reg || ev.ev_ready);
  assign ev_drop = close_now && ev_valid_reg && !ev.ev_ready;

  // Single-entry event register; held contents stay frozen under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_valid_reg <= 1'b0;
      ev_type_reg  <= 1'b0;
      ev_len_reg   <= '0;
    end else if (ev_load) begin
      ev_valid_reg <= 1'b1;
      ev_type_reg  <= close_type;
      ev_len_reg   <= close_len;
    end else if (ev_valid_reg && ev.ev_ready) begin
      ev_valid_reg <= 1'b0;
    end
  end

  // Status counters and sticky flags; clr restarts them but keeps this cycle's events
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_cnt_reg <= '0;
      one_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
      ovf_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else if (clr) begin
      zero_cnt_reg <= (close_now && !close_type) ? CNT_ONE : '0;
      one_cnt_reg  <= (close_now &&  close_type) ? CNT_ONE : '0;
      drop_cnt_reg <= ev_drop ? 8'd1 : 8'd0;
      ovf_reg      <= ev_drop;
      err_reg      <= err_now;
    end else begin
      if (close_now && !close_type && !(&zero_cnt_reg))
        zero_cnt_reg <= zero_cnt_reg + CNT_ONE;
      if (close_now && close_type && !(&one_cnt_reg))
        one_cnt_reg <= one_cnt_reg + CNT_ONE;
      if (ev_drop && !(&drop_cnt_reg))
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      ovf_reg <= ovf_reg | ev_drop;
      err_reg <= err_reg | err_now;
    end
  end

`ifdef MON_MAXLEN_EN
  logic [LEN_W-1:0] max_len_reg;

  // Longest completed run, including runs whose record was dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      max_len_reg <= '0;
    end else if (clr) begin
      max_len_reg <= close_now ? close_len : '0;
    end else if (close_now && (close_len > max_len_reg)) begin
      max_len_reg <= close_len;
    end
  end

  assign max_len = max_len_reg;
`else
  assign max_len = '0;
`endif

  assign ev.ev_valid = ev_valid_reg;
  assign ev.ev_type  = ev_type_reg;
  assign ev.ev_len   = ev_len_reg;
  assign zero_cnt    = zero_cnt_reg;
  assign one_cnt     = one_cnt_reg;
  assign drop_cnt    = drop_cnt_reg;
  assign ovf         = ovf_reg;
  assign err         = err_reg;

endmodule
